// File: rtl/i3c_pkg.sv
// Shared types for the I3C format sequencer: response status codes,
// sequencer states and the payload length width.
package i3c_pkg;

  localparam int SeqLenWidth = 8;

  typedef enum logic [1:0] {
    SEQ_OK      = 2'd0,
    SEQ_NAK     = 2'd1,
    SEQ_TIMEOUT = 2'd2,
    SEQ_ERR     = 2'd3
  } seq_status_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RCNT,
    ST_WAIT_DONE,
    ST_DRAIN,
    ST_RESP
  } seq_state_e;

  function automatic logic [SeqLenWidth-1:0] sat_inc(input logic [SeqLenWidth-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/i3c_seq_watchdog.sv
// Wait-state watchdog: down-counter reloaded on clear, expires after Cycles
// enabled cycles. Only instantiated when I3C_SEQ_WATCHDOG_EN is defined.
module i3c_seq_watchdog #(
  parameter int Cycles = 65535
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CntW = $clog2(Cycles + 1);
  localparam logic [CntW-1:0] Load = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = Load;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= Load;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/i3c_fmt_sequencer.sv
// Turns one transfer descriptor into format-FIFO entries for the controller
// FSM and returns one response per command. Optional watchdog: I3C_SEQ_WATCHDOG_EN.
//
// state      | meaning
// IDLE       | ready for a command
// ADDR       | presenting address entry with START
// WDATA      | passing TX bytes through as format entries
// RCNT       | presenting read-count entry
// WAIT_DONE  | waiting for bus idle (write) or all read bytes
// DRAIN      | discarding unsent TX bytes after a NAK
// RESP       | holding response until accepted
module i3c_fmt_sequencer
  import i3c_pkg::*;
#(
  parameter int MaxLen         = 255,
  parameter int WatchdogCycles = 65535
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [6:0]  cmd_addr_i,
  input  logic        cmd_rnw_i,
  input  logic [7:0]  cmd_len_i,
  input  logic        cmd_stop_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [7:0]  tx_data_i,
  output logic        fmt_valid_o,
  input  logic        fmt_pop_i,
  output logic [7:0]  fmt_byte_o,
  output logic        fmt_start_o,
  output logic        fmt_stop_o,
  output logic        fmt_read_o,
  output logic        fmt_rcont_o,
  output logic        fmt_nakok_o,
  input  logic        rx_wvalid_i,
  input  logic        event_nak_i,
  input  logic        host_idle_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output seq_status_e resp_status_o,
  output logic [7:0]  resp_count_o
);

  localparam logic [SeqLenWidth-1:0] MaxLenB = SeqLenWidth'(MaxLen);

  seq_state_e              state_q, state_d;
  seq_status_e             status_q, status_d;
  logic [6:0]              addr_q, addr_d;
  logic                    rnw_q, rnw_d;
  logic                    stop_q, stop_d;
  logic [SeqLenWidth-1:0]  len_q, len_d;
  logic [SeqLenWidth-1:0]  count_q, count_d;
  logic [SeqLenWidth-1:0]  drain_q, drain_d;
  logic                    pop_hs;
  logic                    wd_expired;

`ifdef I3C_SEQ_WATCHDOG_EN
  i3c_seq_watchdog #(.Cycles(WatchdogCycles)) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (state_d != state_q),
    .en_i      ((state_q == ST_WAIT_DONE) || (state_q == ST_DRAIN)),
    .expired_o (wd_expired)
  );
`else
  logic wd_param_unused;
  assign wd_param_unused = ^WatchdogCycles;
  assign wd_expired = 1'b0;
`endif

  assign pop_hs = fmt_pop_i && tx_valid_i;

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    addr_d   = addr_q;
    rnw_d    = rnw_q;
    stop_d   = stop_q;
    len_d    = len_q;
    count_d  = count_q;
    drain_d  = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          addr_d   = cmd_addr_i;
          rnw_d    = cmd_rnw_i;
          stop_d   = cmd_stop_i;
          len_d    = cmd_len_i;
          count_d  = '0;
          status_d = SEQ_OK;
          if ((cmd_rnw_i && cmd_len_i == '0) || cmd_len_i > MaxLenB) begin
            status_d = SEQ_ERR;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (event_nak_i) begin
          status_d = SEQ_NAK;
          if (!rnw_q && len_q != '0) begin
            drain_d = len_q;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RESP;
          end
        end else if (fmt_pop_i) begin
          if (rnw_q)              state_d = ST_RCNT;
          else if (len_q != '0)   state_d = ST_WDATA;
          else                    state_d = ST_WAIT_DONE;
        end
      end
      ST_WDATA: begin
        // A byte popped in the NAK cycle has left the TX stream, so it counts.
        if (pop_hs) count_d = sat_inc(count_q);
        if (event_nak_i) begin
          status_d = SEQ_NAK;
          if (count_d != len_q) begin
            drain_d = len_q - count_d;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RESP;
          end
        end else if (pop_hs && count_d == len_q) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_RCNT: begin
        if (event_nak_i) begin
          status_d = SEQ_NAK;
          state_d  = ST_RESP;
        end else if (fmt_pop_i) begin
          state_d  = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (rnw_q && rx_wvalid_i) count_d = sat_inc(count_q);
        if (event_nak_i) begin
          status_d = SEQ_NAK;
          state_d  = ST_RESP;
        end else if (rnw_q ? (count_d == len_q) : host_idle_i) begin
          status_d = SEQ_OK;
          state_d  = ST_RESP;
        end else if (wd_expired) begin
          status_d = SEQ_TIMEOUT;
          state_d  = ST_RESP;
        end
      end
      ST_DRAIN: begin
        if (tx_valid_i) begin
          drain_d = drain_q - 1'b1;
          if (drain_q == 8'd1) state_d = ST_RESP;
        end
        if (wd_expired && state_d == ST_DRAIN) begin
          status_d = SEQ_TIMEOUT;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      status_q <= SEQ_OK;
      addr_q   <= '0;
      rnw_q    <= 1'b0;
      stop_q   <= 1'b0;
      len_q    <= '0;
      count_q  <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      addr_q   <= addr_d;
      rnw_q    <= rnw_d;
      stop_q   <= stop_d;
      len_q    <= len_d;
      count_q  <= count_d;
      drain_q  <= drain_d;
    end
  end

  // Outputs decode the registered state; only WDATA passes TX through.
  always_comb begin
    cmd_ready_o  = 1'b0;
    tx_ready_o   = 1'b0;
    fmt_valid_o  = 1'b0;
    fmt_byte_o   = '0;
    fmt_start_o  = 1'b0;
    fmt_stop_o   = 1'b0;
    fmt_read_o   = 1'b0;
    fmt_rcont_o  = 1'b0;
    resp_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE:  cmd_ready_o = 1'b1;
      ST_ADDR: begin
        fmt_valid_o = 1'b1;
        fmt_byte_o  = {addr_q, rnw_q};
        fmt_start_o = 1'b1;
        fmt_stop_o  = stop_q && !rnw_q && (len_q == '0);
      end
      ST_WDATA: begin
        fmt_valid_o = tx_valid_i;
        fmt_byte_o  = tx_data_i;
        tx_ready_o  = fmt_pop_i;
        fmt_stop_o  = stop_q && (count_q == len_q - 1'b1);
      end
      ST_RCNT: begin
        fmt_valid_o = 1'b1;
        fmt_byte_o  = len_q;
        fmt_read_o  = 1'b1;
        fmt_stop_o  = stop_q;
        fmt_rcont_o = !stop_q;
      end
      ST_DRAIN: tx_ready_o   = 1'b1;
      ST_RESP:  resp_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign fmt_nakok_o   = 1'b0;
  assign resp_status_o = status_q;
  assign resp_count_o  = count_q;

endmodule

// File: doc/i3c_fmt_sequencer.md
# i3c_fmt_sequencer

Command sequencer that sits between the HCI command path and `i2c_controller_fsm`. It accepts one transfer descriptor at a time (target address, direction, length, stop), and emits the matching format-FIFO entries to the controller FSM. Write payload bytes come from a TX stream; read bytes are counted back from the controller. It returns one response (status and byte count) per command, replacing the raw `fmt_*` top-level inputs of `i3c`.

## Interface
- `MaxLen`, default 255: largest legal `cmd_len_i`. Must be ≤255.
- `WatchdogCycles`, default 65535: cycles allowed in a wait state. Used only with the watchdog macro.

Ports:
- `clk_i` in 1: the block's single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `cmd_valid_i` in 1, `cmd_ready_o` out 1: command handshake.
- `cmd_addr_i` in 7: target address.
- `cmd_rnw_i` in 1: 1 = read.
- `cmd_len_i` in 8: payload byte count.
- `cmd_stop_i` in 1: end the transfer with STOP.
- `tx_valid_i` in 1, `tx_ready_o` out 1, `tx_data_i` in 8: write payload stream.
- `fmt_valid_o` out 1: format entry available. Connects to `fmt_fifo_rvalid_i`.
- `fmt_pop_i` in 1: controller consumes the entry. Connects to `fmt_fifo_rready_o`.
- `fmt_byte_o` out 8: format byte.
- `fmt_start_o` out 1, `fmt_stop_o` out 1, `fmt_read_o` out 1, `fmt_rcont_o` out 1, `fmt_nakok_o` out 1: format flags.
- `rx_wvalid_i` in 1: a read byte was delivered by the controller.
- `event_nak_i` in 1: NAK event from the controller.
- `host_idle_i` in 1: controller is idle.
- `resp_valid_o` out 1, `resp_ready_i` in 1: response handshake.
- `resp_status_o` out 2: response status, type `seq_status_e`.
- `resp_count_o` out 8: bytes transferred.

## Operation
- **States:** IDLE, ADDR, WDATA, RCNT, WAIT_DONE, DRAIN, RESP.
- **IDLE**
  - `cmd_ready_o` = 1 only in this state.
  - On a command handshake, latch the command and clear the count.
  - If `rnw=1` and `len=0`, or `len>MaxLen`: go to RESP with status ERR (2'd3) and issue no bus traffic.
  - Otherwise go to ADDR.
- **ADDR**
  - Drive `fmt_byte_o={addr,rnw}` with `fmt_start_o=1`.
  - `fmt_stop_o` = `stop` when this is a write with `len=0`.
  - On `fmt_pop_i`:
    - write with `len>0` → WDATA;
    - read → RCNT;
    - otherwise → WAIT_DONE.
- **WDATA**
  - `fmt_valid_o` = `tx_valid_i`; `fmt_byte_o` = `tx_data_i`; `tx_ready_o` = `fmt_pop_i` (combinational pass-through).
  - On the last byte, `fmt_stop_o` = `stop`.
  - Each pop increments the count. After the last pop → WAIT_DONE.
- **RCNT**
  - Drive `fmt_byte_o=len`, `fmt_read_o=1`, `fmt_stop_o=stop`.
  - `fmt_rcont_o` = `!stop`.
  - Pop → WAIT_DONE.
- **WAIT_DONE**
  - A read counts `rx_wvalid_i` pulses.
  - The command is done when `host_idle_i=1` (write) or the count equals `len` (read).
  - Done → RESP with status OK (2'd0).
- **NAK handling**
  - `event_nak_i` in ADDR, WDATA, RCNT or WAIT_DONE sets status NAK (2'd1).
  - Remaining write bytes go to DRAIN; otherwise go straight to RESP.
  - `fmt_valid_o` = 0 after the NAK.
- **DRAIN**
  - `tx_ready_o` = 1. Discard `len-count` bytes, then → RESP.
- **RESP**
  - `resp_valid_o` = 1, held until `resp_ready_i`, then → IDLE.
  - Status and count stay stable while valid.
- `fmt_nakok_o` = 0 always.
- **Simultaneous events**
  - NAK in the same cycle as the final pop: NAK wins.
  - `rx_wvalid_i` in the same cycle as count reaching `len`: completes that cycle.
- The count saturates at 255.

## Timing
- **Reset values:** all outputs 0. The only exception is `cmd_ready_o`, which is 1 because the block resets into IDLE.
- A reset assertion at any point aborts the command in flight. No response is produced for it.
- **Latency:**
  - Command accept → `fmt_valid_o` high: 1 cycle.
  - Pop → next entry: 1 cycle.
  - Done condition → `resp_valid_o`: 1 cycle.
- All FSM outputs are driven from registers. The exception is the WDATA pass-through, which is combinational.
- At most one command is in flight. A back-to-back accept is possible one cycle after a response handshake.

## Configuration
- `I3C_SEQ_WATCHDOG_EN` defined:
  - A counter runs in WAIT_DONE and DRAIN and clears on state entry.
  - Reaching `WatchdogCycles` → RESP with status TIMEOUT (2'd2).
- `I3C_SEQ_WATCHDOG_EN` undefined:
  - No counter logic is built, and status 2'd2 is never produced.

## Structure
- `i3c_pkg` holds:
  - `seq_status_e` (OK/NAK/TIMEOUT/ERR, 2 bits);
  - `seq_state_e`;
  - `SeqLenWidth=8`.
- Sub-module `i3c_seq_watchdog`: a counter with clear, enable and expiry. It is instantiated only under `I3C_SEQ_WATCHDOG_EN`.

## Test plan
- **Write:** addr 0x50, len 3, stop, TX AA/BB/CC, pop each cycle → entries {0xA0 start}, AA, BB, {CC stop}; then `host_idle_i` → resp OK, count 3.
- **Read:** addr 0x21, len 4 → {0x43 start}, {0x04 read stop}; 4 `rx_wvalid_i` pulses → resp OK, count 4.
- **NAK on address:** write len 2 with NAK after the address pop → 2 TX bytes drained, no more entries, resp NAK, count 0.
- **Error:** read len 0 → resp ERR within 2 cycles, `fmt_valid_o` never asserts.
- **Watchdog:** with macro, `WatchdogCycles=16`, write with `host_idle_i` held low → TIMEOUT exactly 16 cycles after WAIT_DONE entry. Without macro, the block remains in WAIT_DONE.
- **Reset:** `rst_ni` low during WDATA → all outputs 0 immediately, `cmd_ready_o=1` after release.
